// File: rtl/holy_core_pkg.sv
// Shared trap/CSR definitions for the machine-mode trap controller.
// CSR addresses, interrupt cause codes and the trap FSM state type.
package holy_core_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [30:0] CAUSE_M_SOFT  = 31'd3;
    localparam logic [30:0] CAUSE_M_TIMER = 31'd7;
    localparam logic [30:0] CAUSE_M_EXT   = 31'd11;

    localparam int MCAUSE_IRQ_BIT = 31;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    typedef enum logic {
        TRAP_IDLE,
        TRAP_WAIT_COMMIT
    } trap_state_t;

endpackage

// File: rtl/trap_irq_arbiter.sv
// Machine interrupt arbiter: masks pending lines with mie and mstatus.MIE.
// Priority is external > software > timer.
module trap_irq_arbiter
    import holy_core_pkg::*;
(
    input  logic [31:0] mip,
    input  logic [31:0] mie,
    input  logic        mstatus_mie,
    output logic        take_irq,
    output logic [30:0] cause
);

    logic [31:0] pending;

    // Select the highest-priority enabled pending interrupt
    always_comb begin
        pending  = mip & mie;
        take_irq = mstatus_mie & (|pending);
        cause    = '0;
        if (pending[11]) begin
            cause = CAUSE_M_EXT;
        end else if (pending[3]) begin
            cause = CAUSE_M_SOFT;
        end else if (pending[7]) begin
            cause = CAUSE_M_TIMER;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap controller: trap sequencing, MRET and M-mode CSRs.
// Optional vectored mtvec mode is enabled by HOLY_TRAP_VECTORED_EN.
module trap_controller
    import holy_core_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MIE_RESET   = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [30:0] exception_cause,
    input  logic        m_ret,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        irq_external,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_we,
    output logic [31:0] csr_rdata,
    output logic        trap,
    output logic [31:0] trap_target,
    output logic [31:0] mret_target,
    output logic        global_ie
);

`ifdef HOLY_TRAP_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    trap_state_t state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic [31:0] mip;
    logic        take_irq;
    logic [30:0] irq_cause;
    logic        csr_wr;

    assign mip = {20'b0, irq_external, 3'b0, irq_timer,
                  3'b0, irq_software, 3'b0};

    trap_irq_arbiter u_arb (
        .mip         (mip),
        .mie         (mie_q),
        .mstatus_mie (mstatus_mie_q),
        .take_irq    (take_irq),
        .cause       (irq_cause)
    );

    // Next-state, trap request and CSR update logic
    always_comb begin
        state_d       = state_q;
        mstatus_mie_d = mstatus_mie_q;
        mpie_d        = mpie_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        trap          = 1'b0;
        csr_wr        = csr_we & ~stall;

        unique case (state_q)
            TRAP_IDLE: begin
                trap = exception | take_irq;
                if (trap) begin
                    state_d = stall ? TRAP_WAIT_COMMIT : TRAP_IDLE;
                end
            end
            TRAP_WAIT_COMMIT: begin
                if (!stall) begin
                    state_d = TRAP_IDLE;
                end
            end
            default: state_d = TRAP_IDLE;
        endcase

        if (csr_wr) begin
            unique case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d = csr_wdata[3];
                    mpie_d        = csr_wdata[7];
                end
                CSR_MIE:    mie_d    = csr_wdata & IRQ_MASK;
                CSR_MTVEC:  mtvec_d  = csr_wdata & MTVEC_MASK;
                CSR_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (state_q == TRAP_IDLE && m_ret && !trap && !stall) begin
            mstatus_mie_d = mpie_q;
            mpie_d        = 1'b1;
        end

        if (trap) begin
            mepc_d        = pc;
            mcause_d      = exception ? {1'b0, exception_cause}
                                      : {1'b1, irq_cause};
            mpie_d        = mstatus_mie_q;
            mstatus_mie_d = 1'b0;
        end
    end

    // State and CSR registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= TRAP_IDLE;
            mstatus_mie_q <= 1'b0;
            mpie_q        <= 1'b0;
            mie_q         <= MIE_RESET & IRQ_MASK;
            mtvec_q       <= MTVEC_RESET & MTVEC_MASK;
            mepc_q        <= '0;
            mcause_q      <= '0;
        end else begin
            state_q       <= state_d;
            mstatus_mie_q <= mstatus_mie_d;
            mpie_q        <= mpie_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
        end
    end

    // Combinational CSR read mux
    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr)
            CSR_MSTATUS: csr_rdata = {24'b0, mpie_q, 3'b0,
                                      mstatus_mie_q, 3'b0};
            CSR_MIE:     csr_rdata = mie_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MIP:     csr_rdata = mip;
            default:     csr_rdata = '0;
        endcase
    end

`ifdef HOLY_TRAP_VECTORED_EN
    logic        sel_irq;
    logic [29:0] sel_cause;

    // Vector interrupts off the live cause on the trap cycle, else mcause
    always_comb begin
        sel_irq     = trap ? ~exception : mcause_q[MCAUSE_IRQ_BIT];
        sel_cause   = trap ? irq_cause[29:0] : mcause_q[29:0];
        trap_target = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && sel_irq) begin
            trap_target = {mtvec_q[31:2], 2'b00} + {sel_cause, 2'b00};
        end
    end
`else
    assign trap_target = {mtvec_q[31:2], 2'b00};
`endif

    assign mret_target = mepc_q;
    assign global_ie   = mstatus_mie_q;

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap responder paired with the control unit.
- Consumes the control unit's exception/exception_cause/m_ret outputs, the current instruction PC, the global stall and three interrupt lines.
- Produces the one-cycle trap request, the trap/return target PCs and the global interrupt enable.
- Owns mstatus.MIE/MPIE, mie, mtvec, mepc, mcause and a read-only mip view, and exposes them through a simple CSR port.

Parameters:
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec (base and mode).
- MIE_RESET, 32'h0000_0000: reset value of the mie register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- exception  in  1  synchronous exception from control.
- exception_cause  in  31  exception code from control.
- m_ret  in  1  MRET decoded.
- pc  in  32  PC of the current instruction.
- stall  in  1  global core stall; the PC holds while high.
- irq_software  in  1  level, machine software interrupt.
- irq_timer  in  1  level, machine timer interrupt.
- irq_external  in  1  level, machine external interrupt.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  CSR write data (already op-resolved).
- csr_we  in  1  CSR write strobe.
- csr_rdata  out  32  CSR read data, combinational from csr_addr.
- trap  out  1  trap request, high for exactly one cycle per trap.
- trap_target  out  32  PC to load on trap.
- mret_target  out  32  current mepc.
- global_ie  out  1  mstatus.MIE.

Behaviour:
- Reset values:
  - State IDLE; trap=0; global_ie=0; MPIE=0.
  - mepc=0, mcause=0, mtvec=MTVEC_RESET, mie=MIE_RESET.
- mip is combinational: {irq_external@bit11, irq_timer@bit7, irq_software@bit3}; all other bits 0.
- take_irq = MIE & |(mip & mie). Interrupt priority: external(11) > software(3) > timer(7).
- Exceptions are never masked and win over interrupts in the same cycle.
- State IDLE, combinational trap = exception | take_irq.
  - On that edge: mepc<=pc; mcause<={is_irq, cause}; MPIE<=MIE; MIE<=0.
  - Next state: stall ? WAIT_COMMIT : IDLE.
- State WAIT_COMMIT:
  - trap=0; exception, take_irq and m_ret are ignored, because the stalled instruction still presents them.
  - First cycle with stall=0 (the PC loads mtvec): go to IDLE.
- m_ret in IDLE with no trap and stall=0: MIE<=MPIE, MPIE<=1.
  - m_ret is not committed while stall=1, to prevent a double restore.
  - If a trap and m_ret occur together, the trap wins and the m_ret is dropped.
- CSR writes apply only when csr_we=1 and stall=0, at:
  - 0x300: MIE=bit3, MPIE=bit7; other bits read 0.
  - 0x304 mie: bits 3, 7, 11 only.
  - 0x305 mtvec.
  - 0x341 mepc: bits[1:0] forced 0.
  - 0x342 mcause.
- mip (0x344) ignores writes. Unknown addresses read 0 and ignore writes.
- A trap update on the same edge overrides any CSR write to mstatus, mepc or mcause.
- trap_target = {mtvec[31:2],2'b00}; vectored rule under the optional feature.
- mret_target = mepc.
- Reset asserted in WAIT_COMMIT returns to IDLE with all reset values.

Optional Feature:
- Macro: HOLY_TRAP_VECTORED_EN.
- Defined:
  - mtvec[1:0] is writable.
  - Mode 1 with an interrupt gives trap_target = base + 4*cause.
  - Exceptions always use base.
  - Modes 2 and 3 behave as mode 0.
- Undefined: mtvec[1:0] reads 0 and ignores writes; all traps go to base.

Decomposition:
- holy_core_pkg additions:
  - CSR address constants (CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIP).
  - Cause constants CAUSE_M_SOFT=3, CAUSE_M_TIMER=7, CAUSE_M_EXT=11.
  - MCAUSE_IRQ_BIT=31.
  - trap_state_t enum {TRAP_IDLE, TRAP_WAIT_COMMIT}.
- One sub-module: trap_irq_arbiter (combinational).
  - Inputs: mip, mie, MIE.
  - Outputs: take_irq and the 31-bit cause.

Test Plan:
- ECALL: exception=1, cause=11, pc=0x100, stall=0, mtvec=0x200 → trap pulse for 1 cycle; mepc=0x100; mcause=0x0000000B; MIE 1→0; MPIE=1.
- Stalled trap: exception held 3 cycles with stall=1 → trap high only in the first cycle; state WAIT_COMMIT; returns to IDLE on the stall=0 cycle; mepc stays at the first pc.
- Priority: MIE=1, mie=0x888, all irqs high together with exception cause 2 → mcause=2. Same with no exception → mcause=0x8000000B.
- MRET: MPIE=1, MIE=0, m_ret=1 with stall=1 for 2 cycles then 0 → MIE changes only on the stall=0 edge; MIE=1, MPIE=1; mret_target=mepc.
- With HOLY_TRAP_VECTORED_EN: mtvec=0x1001 plus timer interrupt → trap_target=0x101C. Without it: writing mtvec=0x1001 reads back 0x1000 and trap_target=0x1000.
- CSR write collision: csr_we to mepc=0x500 on the trap edge with pc=0x40 → mepc=0x40.
